// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker: rebuilds the generator recurrence from
// received bits, locks after a run of correct predictions, then counts errors.
module prbs_checker #(
  parameter int unsigned        width        = 32,
  parameter logic [width-1:0]   polynomial   = '0,
  parameter int unsigned        lock_matches = 64,
  parameter int unsigned        window       = 256,
  parameter int unsigned        loss_errors  = 8,
  parameter int unsigned        cnt_width    = 32
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 clear,
  input  logic                 d_in,
  input  logic                 d_valid,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [cnt_width-1:0] err_count,
  output logic [cnt_width-1:0] bit_count
);

  localparam int unsigned FW  = $clog2(width + 1);
  localparam int unsigned MW  = $clog2(lock_matches + 1);
  localparam int unsigned PW  = $clog2(window);
  localparam int unsigned EW  = $clog2(loss_errors + 1);

  localparam logic [FW-1:0] FILL_LAST  = FW'(width - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(lock_matches - 1);
  localparam logic [PW-1:0] WIN_LAST   = PW'(window - 1);
  localparam logic [EW-1:0] LOSS_LIM   = EW'(loss_errors);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_SEARCH,
    ST_LOCKED
  } state_e;

  state_e               st_q, st_d;
  logic [width-1:0]     hist_q, hist_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic [MW-1:0]        match_q, match_d;
  logic [PW-1:0]        wpos_q, wpos_d;
  logic [EW-1:0]        werr_q, werr_d;
  logic                 locked_q, locked_d;
  logic                 pulse_q, pulse_d;
  logic [cnt_width-1:0] ec_q, ec_d;
  logic [cnt_width-1:0] bc_q, bc_d;

  logic                 pred;
  logic                 mism;
  logic [EW-1:0]        werr_nx;

  function automatic logic [cnt_width-1:0] sat_inc(input logic [cnt_width-1:0] v);
    return (&v) ? v : v + cnt_width'(1);
  endfunction

  // hist_q[0] is the oldest bit; bit 0 of the tap vector is implied by it.
  assign pred    = hist_q[0] ^ (^(polynomial[width-1:1] & hist_q[width-1:1]));
  assign mism    = d_in ^ pred;
  assign werr_nx = werr_q + EW'(mism);

  always_comb begin
    st_d     = st_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    match_d  = match_q;
    wpos_d   = wpos_q;
    werr_d   = werr_q;
    locked_d = locked_q;
    pulse_d  = 1'b0;
    ec_d     = ec_q;
    bc_d     = bc_q;
    if (clear) begin
      st_d     = ST_FILL;
      hist_d   = '0;
      fill_d   = '0;
      match_d  = '0;
      wpos_d   = '0;
      werr_d   = '0;
      locked_d = 1'b0;
      ec_d     = '0;
      bc_d     = '0;
    end else if (d_valid) begin
      unique case (st_q)
        ST_FILL: begin
          hist_d = {d_in, hist_q[width-1:1]};
          fill_d = fill_q + FW'(1);
          if (fill_q == FILL_LAST) begin
            st_d    = ST_SEARCH;
            match_d = '0;
          end
        end
        ST_SEARCH: begin
          hist_d = {d_in, hist_q[width-1:1]};
          if (!mism) begin
            match_d = match_q + MW'(1);
            if (match_q == MATCH_LAST) begin
              st_d     = ST_LOCKED;
              locked_d = 1'b1;
              wpos_d   = '0;
              werr_d   = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        ST_LOCKED: begin
          // Free-run on the prediction so a channel error never enters hist.
          hist_d  = {pred, hist_q[width-1:1]};
          bc_d    = sat_inc(bc_q);
          pulse_d = mism;
          if (mism) ec_d = sat_inc(ec_q);
          if (werr_nx == LOSS_LIM) begin
            st_d     = ST_FILL;
            fill_d   = '0;
            locked_d = 1'b0;
            werr_d   = werr_nx;
          end else if (wpos_q == WIN_LAST) begin
            wpos_d = '0;
            werr_d = '0;
          end else begin
            wpos_d = wpos_q + PW'(1);
            werr_d = werr_nx;
          end
        end
        default: st_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      st_q     <= ST_FILL;
      hist_q   <= '0;
      fill_q   <= '0;
      match_q  <= '0;
      wpos_q   <= '0;
      werr_q   <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      ec_q     <= '0;
      bc_q     <= '0;
    end else begin
      st_q     <= st_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      wpos_q   <= wpos_d;
      werr_q   <= werr_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
      ec_q     <= ec_d;
      bc_q     <= bc_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = pulse_q;
  assign err_count = ec_q;
  assign bit_count = bc_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: an in-bench generator drives the stream,
// a behavioural model queues expected outputs, scenario checks pin key points.
module tb_prbs_checker;
  localparam int         W    = 8;
  localparam logic [7:0] POLY = 8'h1D;
  localparam int         LM   = 16;
  localparam int         WIN  = 32;
  localparam int         LE   = 4;
  localparam int         CW   = 8;

  logic          clk = 1'b0;
  logic          res_n, clear, d_in, d_valid;
  logic          locked, err_pulse;
  logic [CW-1:0] err_count, bit_count;

  prbs_checker #(
    .width(W), .polynomial(POLY), .lock_matches(LM),
    .window(WIN), .loss_errors(LE), .cnt_width(CW)
  ) dut (
    .clk(clk), .res_n(res_n), .clear(clear), .d_in(d_in), .d_valid(d_valid),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic       lk;
    logic       pl;
    logic [7:0] ec;
    logic [7:0] bc;
  } exp_t;
  exp_t sb[$];

  logic [7:0] g;
  logic [7:0] poly_v;

  int         m_st, m_fill, m_match, m_wpos, m_werr, m_ec, m_bc;
  logic [7:0] m_h;
  logic       m_lk, m_pl;

  task automatic model_reset();
    m_st = 0; m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0;
    m_ec = 0; m_bc = 0; m_h = '0; m_lk = 1'b0; m_pl = 1'b0;
  endtask

  task automatic model(input logic v, input logic b, input logic clr);
    logic p;
    if (clr) begin
      model_reset();
      return;
    end
    m_pl = 1'b0;
    if (!v) return;
    p = m_h[0] ^ (^(poly_v[7:1] & m_h[7:1]));
    case (m_st)
      0: begin
        m_h = {b, m_h[7:1]};
        m_fill++;
        if (m_fill == W) begin m_st = 1; m_match = 0; end
      end
      1: begin
        m_h = {b, m_h[7:1]};
        if (b == p) begin
          m_match++;
          if (m_match == LM) begin m_st = 2; m_lk = 1'b1; m_wpos = 0; m_werr = 0; end
        end else m_match = 0;
      end
      default: begin
        m_h = {p, m_h[7:1]};
        if (m_bc < 255) m_bc++;
        if (b != p) begin
          if (m_ec < 255) m_ec++;
          m_pl = 1'b1;
          m_werr++;
        end
        if (m_werr == LE) begin m_st = 0; m_fill = 0; m_lk = 1'b0; end
        else if (m_wpos == WIN - 1) begin m_wpos = 0; m_werr = 0; end
        else m_wpos++;
      end
    endcase
  endtask

  // One clock: drive inputs, queue the model's expectation, compare after the edge.
  task automatic step(input logic v, input logic inv, input logic clr);
    logic b;
    exp_t e;
    b = 1'b0;
    if (v) begin
      b = g[0] ^ (^(poly_v[7:1] & g[7:1]));
      g = {b, g[7:1]};
    end
    d_valid = v;
    d_in    = b ^ inv;
    clear   = clr;
    model(v, b ^ inv, clr);
    e.lk = m_lk; e.pl = m_pl; e.ec = 8'(m_ec); e.bc = 8'(m_bc);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else begin
      e = sb.pop_front();
      chk("sb_locked", locked, e.lk);
      chk("sb_pulse", err_pulse, e.pl);
      chk("sb_errcnt", err_count, e.ec);
      chk("sb_bitcnt", bit_count, e.bc);
    end
    d_valid = 1'b0;
    clear   = 1'b0;
  endtask

  task automatic relock();
    step(1'b0, 1'b0, 1'b1);
    repeat (LM + W) step(1'b1, 1'b0, 1'b0);
    chk("relock", locked, 1'b1);
  endtask

  initial begin
    int vcnt;
    int cyc;
    poly_v  = POLY;
    g       = 8'hA5;
    res_n   = 1'b0;
    clear   = 1'b0;
    d_in    = 1'b0;
    d_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", locked, 1'b0);
    chk("rst_pulse", err_pulse, 1'b0);
    chk("rst_errcnt", err_count, 8'd0);
    chk("rst_bitcnt", bit_count, 8'd0);
    res_n = 1'b1;

    // Reset/lock
    for (int i = 1; i <= 30; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (i == 23) chk("lock_pre24", locked, 1'b0);
      if (i == 24) begin
        chk("lock_at24", locked, 1'b1);
        chk("bitcnt_at24", bit_count, 8'd0);
      end
      if (i == 25) chk("bitcnt_at25", bit_count, 8'd1);
    end
    chk("lock_errcnt", err_count, 8'd0);

    // Single error
    relock();
    repeat (5) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("single_pulse", err_pulse, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("single_pulse_off", err_pulse, 1'b0);
    repeat (40) step(1'b1, 1'b0, 1'b0);
    chk("single_errcnt", err_count, 8'd1);
    chk("single_locked", locked, 1'b1);

    // Lock loss
    relock();
    repeat (3) step(1'b1, 1'b1, 1'b0);
    chk("loss_pre", locked, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    chk("loss_unlocked", locked, 1'b0);
    chk("loss_errcnt", err_count, 8'd4);
    repeat (23) step(1'b1, 1'b0, 1'b0);
    chk("relock_pre24", locked, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("relock_at24", locked, 1'b1);

    // Window rollover
    relock();
    repeat (3) step(1'b1, 1'b1, 1'b0);
    repeat (29) step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    chk("win_locked", locked, 1'b1);
    chk("win_errcnt", err_count, 8'd6);
    repeat (28) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("win_last_loss", locked, 1'b0);
    chk("win_last_errcnt", err_count, 8'd7);

    // Valid gaps
    step(1'b0, 1'b0, 1'b1);
    vcnt = 0;
    cyc  = 0;
    while (vcnt < 30 && cyc < 2000) begin
      logic v;
      v = ($urandom_range(0, 99) < 30);
      step(v, 1'b0, 1'b0);
      cyc++;
      if (v) begin
        vcnt++;
        if (vcnt == 23) chk("gap_pre24", locked, 1'b0);
        if (vcnt == 24) chk("gap_at24", locked, 1'b1);
      end
    end
    chk("gap_budget", 32'(vcnt), 32'd30);
    chk("gap_errcnt", err_count, 8'd0);

    // Clear mid-lock, with a valid errored bit on the same cycle
    relock();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_locked", locked, 1'b0);
    chk("clr_pulse", err_pulse, 1'b0);
    chk("clr_errcnt", err_count, 8'd0);
    chk("clr_bitcnt", bit_count, 8'd0);

    // Asynchronous reset pulse between edges
    relock();
    step(1'b1, 1'b1, 1'b0);
    res_n = 1'b0;
    #2;
    chk("arst_locked", locked, 1'b0);
    chk("arst_pulse", err_pulse, 1'b0);
    chk("arst_errcnt", err_count, 8'd0);
    chk("arst_bitcnt", bit_count, 8'd0);
    model_reset();
    #1;
    res_n = 1'b1;

    // Saturation: errors spaced so no window ever holds four
    relock();
    for (int e = 0; e < 300; e++) begin
      step(1'b1, 1'b1, 1'b0);
      repeat (10) step(1'b1, 1'b0, 1'b0);
    end
    chk("sat_errcnt", err_count, 8'hFF);
    chk("sat_bitcnt", bit_count, 8'hFF);
    chk("sat_locked", locked, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
